// File: rtl/br_sched.sv
// In-order branch scheduling queue: buffers decoded branches, wakes operands from the CDB,
// issues the oldest ready branch to the shared comparator and registers the resolution record.
module br_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int ROB_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_enq_valid,
    output logic             o_enq_ready,
    input  logic [2:0]       i_enq_cmp_op,
    input  logic [31:0]      i_enq_a,
    input  logic [31:0]      i_enq_b,
    input  logic             i_enq_a_rdy,
    input  logic             i_enq_b_rdy,
    input  logic [TAG_W-1:0] i_enq_a_tag,
    input  logic [TAG_W-1:0] i_enq_b_tag,
    input  logic [31:0]      i_enq_pc,
    input  logic [31:0]      i_enq_target,
    input  logic             i_enq_pred_taken,
    input  logic [ROB_W-1:0] i_enq_rob_id,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [31:0]      i_cdb_data,
    output logic [31:0]      o_cmp_a,
    output logic [31:0]      o_cmp_b,
    output logic [2:0]       o_cmp_op,
    input  logic             i_cmp_br_en,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_res_taken,
    output logic             o_res_mispredict,
    output logic [31:0]      o_res_redirect_pc,
    output logic [ROB_W-1:0] o_res_rob_id
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             r_vld     [DEPTH];
    logic [31:0]      r_a       [DEPTH];
    logic [31:0]      r_b       [DEPTH];
    logic             r_a_rdy   [DEPTH];
    logic             r_b_rdy   [DEPTH];
    logic [TAG_W-1:0] r_a_tag   [DEPTH];
    logic [TAG_W-1:0] r_b_tag   [DEPTH];
    logic [2:0]       r_op      [DEPTH];
    logic [31:0]      r_pc      [DEPTH];
    logic [31:0]      r_tgt     [DEPTH];
    logic             r_pred    [DEPTH];
    logic [ROB_W-1:0] r_rob     [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_res_valid;
    logic             r_res_taken;
    logic             r_res_mispredict;
    logic [31:0]      r_res_redirect_pc;
    logic [ROB_W-1:0] r_res_rob_id;

    logic             w_nonempty;
    logic             w_enq;
    logic             w_issue;
    logic             w_res_free;
    logic             w_enq_a_byp;
    logic             w_enq_b_byp;
    logic [31:0]      w_enq_a_val;
    logic [31:0]      w_enq_b_val;
    logic             w_wake_a  [DEPTH];
    logic             w_wake_b  [DEPTH];
    logic             w_taken;

    // Handshake and issue qualification.
    always_comb begin
        w_nonempty  = (r_count != {CNT_W{1'b0}});
        o_enq_ready = (r_count != FULL_CNT);
        w_enq       = i_enq_valid && o_enq_ready && !i_flush;
        w_res_free  = !r_res_valid || i_res_ready;
        w_issue     = w_nonempty && r_a_rdy[r_head] && r_b_rdy[r_head] && w_res_free && !i_flush;
    end

    // Operands broadcast on the CDB in the enqueue cycle are stored already captured.
    always_comb begin
        w_enq_a_byp = !i_enq_a_rdy && i_cdb_valid && (i_enq_a_tag == i_cdb_tag);
        w_enq_b_byp = !i_enq_b_rdy && i_cdb_valid && (i_enq_b_tag == i_cdb_tag);
        w_enq_a_val = w_enq_a_byp ? i_cdb_data : i_enq_a;
        w_enq_b_val = w_enq_b_byp ? i_cdb_data : i_enq_b;
    end

    // Per-entry tag match against the CDB broadcast.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake_a[i] = i_cdb_valid && r_vld[i] && !r_a_rdy[i] && (r_a_tag[i] == i_cdb_tag);
            w_wake_b[i] = i_cdb_valid && r_vld[i] && !r_b_rdy[i] && (r_b_tag[i] == i_cdb_tag);
        end
    end

    // Entry storage: wakeup capture, issue retirement and enqueue write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]   <= 1'b0;
                r_a[i]     <= 32'h0;
                r_b[i]     <= 32'h0;
                r_a_rdy[i] <= 1'b0;
                r_b_rdy[i] <= 1'b0;
                r_a_tag[i] <= {TAG_W{1'b0}};
                r_b_tag[i] <= {TAG_W{1'b0}};
                r_op[i]    <= 3'b000;
                r_pc[i]    <= 32'h0;
                r_tgt[i]   <= 32'h0;
                r_pred[i]  <= 1'b0;
                r_rob[i]   <= {ROB_W{1'b0}};
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]   <= 1'b0;
                r_a_rdy[i] <= 1'b0;
                r_b_rdy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wake_a[i]) begin
                    r_a[i]     <= i_cdb_data;
                    r_a_rdy[i] <= 1'b1;
                end
                if (w_wake_b[i]) begin
                    r_b[i]     <= i_cdb_data;
                    r_b_rdy[i] <= 1'b1;
                end
            end
            if (w_issue) begin
                r_vld[r_head] <= 1'b0;
            end
            // The tail slot is always free when enqueuing, so it never collides with wakeup.
            if (w_enq) begin
                r_vld[r_tail]   <= 1'b1;
                r_a[r_tail]     <= w_enq_a_val;
                r_b[r_tail]     <= w_enq_b_val;
                r_a_rdy[r_tail] <= i_enq_a_rdy || w_enq_a_byp;
                r_b_rdy[r_tail] <= i_enq_b_rdy || w_enq_b_byp;
                r_a_tag[r_tail] <= i_enq_a_tag;
                r_b_tag[r_tail] <= i_enq_b_tag;
                r_op[r_tail]    <= i_enq_cmp_op;
                r_pc[r_tail]    <= i_enq_pc;
                r_tgt[r_tail]   <= i_enq_target;
                r_pred[r_tail]  <= i_enq_pred_taken;
                r_rob[r_tail]   <= i_enq_rob_id;
            end
        end
    end

    // Circular pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Comparator operands always reflect the head entry, zero when empty.
    always_comb begin
        o_cmp_a  = 32'h0;
        o_cmp_b  = 32'h0;
        o_cmp_op = 3'b000;
        if (w_nonempty) begin
            o_cmp_a  = r_a[r_head];
            o_cmp_b  = r_b[r_head];
            o_cmp_op = r_op[r_head];
        end else begin
            o_cmp_a  = 32'h0;
            o_cmp_b  = 32'h0;
            o_cmp_op = 3'b000;
        end
    end

    // funct3 010/011 are not branches; never report them taken.
    always_comb begin
        w_taken = (o_cmp_op[2:1] == 2'b01) ? 1'b0 : i_cmp_br_en;
    end

    // Resolution record register with valid/ready hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid       <= 1'b0;
            r_res_taken       <= 1'b0;
            r_res_mispredict  <= 1'b0;
            r_res_redirect_pc <= 32'h0;
            r_res_rob_id      <= {ROB_W{1'b0}};
        end else if (i_flush) begin
            r_res_valid <= 1'b0;
        end else if (w_issue) begin
            r_res_valid       <= 1'b1;
            r_res_taken       <= w_taken;
            r_res_mispredict  <= w_taken ^ r_pred[r_head];
            r_res_redirect_pc <= w_taken ? r_tgt[r_head] : (r_pc[r_head] + 32'd4);
            r_res_rob_id      <= r_rob[r_head];
        end else if (r_res_valid && i_res_ready) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    assign o_res_valid       = r_res_valid;
    assign o_res_taken       = r_res_taken;
    assign o_res_mispredict  = r_res_mispredict;
    assign o_res_redirect_pc = r_res_redirect_pc;
    assign o_res_rob_id      = r_res_rob_id;

endmodule

// File: tb/tb_br_sched.sv
// Directed bench for br_sched with a behavioural RV32I comparator on the cmp_* port.
module tb_br_sched;

    logic        clk = 1'b0;
    logic        rst, flush, enq_valid, enq_ready;
    logic [2:0]  enq_cmp_op;
    logic [31:0] enq_a, enq_b, enq_pc, enq_target;
    logic        enq_a_rdy, enq_b_rdy, enq_pred_taken;
    logic [4:0]  enq_a_tag, enq_b_tag, enq_rob_id;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [31:0] cmp_a, cmp_b;
    logic [2:0]  cmp_op;
    logic        cmp_br_en;
    logic        res_valid, res_ready, res_taken, res_mispredict;
    logic [31:0] res_redirect_pc;
    logic [4:0]  res_rob_id;
    logic [39:0] res_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    br_sched #(.DEPTH(4), .TAG_W(5), .ROB_W(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_enq_valid(enq_valid), .o_enq_ready(enq_ready), .i_enq_cmp_op(enq_cmp_op),
        .i_enq_a(enq_a), .i_enq_b(enq_b), .i_enq_a_rdy(enq_a_rdy), .i_enq_b_rdy(enq_b_rdy),
        .i_enq_a_tag(enq_a_tag), .i_enq_b_tag(enq_b_tag), .i_enq_pc(enq_pc),
        .i_enq_target(enq_target), .i_enq_pred_taken(enq_pred_taken), .i_enq_rob_id(enq_rob_id),
        .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
        .o_cmp_a(cmp_a), .o_cmp_b(cmp_b), .o_cmp_op(cmp_op), .i_cmp_br_en(cmp_br_en),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_taken(res_taken),
        .o_res_mispredict(res_mispredict), .o_res_redirect_pc(res_redirect_pc),
        .o_res_rob_id(res_rob_id)
    );

    // External comparator; undefined funct3 returns 1 so forcing to not-taken is observable.
    always_comb begin
        case (cmp_op)
            3'b000:  cmp_br_en = (cmp_a == cmp_b);
            3'b001:  cmp_br_en = (cmp_a != cmp_b);
            3'b100:  cmp_br_en = ($signed(cmp_a) <  $signed(cmp_b));
            3'b101:  cmp_br_en = ($signed(cmp_a) >= $signed(cmp_b));
            3'b110:  cmp_br_en = (cmp_a <  cmp_b);
            3'b111:  cmp_br_en = (cmp_a >= cmp_b);
            default: cmp_br_en = 1'b1;
        endcase
    end

    assign res_vec = {res_valid, res_taken, res_mispredict, res_redirect_pc, res_rob_id};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic ar, input logic br, input logic [4:0] at,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pred, input logic [4:0] rob);
        enq_valid = 1'b1; enq_cmp_op = op; enq_a = a; enq_b = b;
        enq_a_rdy = ar; enq_b_rdy = br; enq_a_tag = at; enq_b_tag = 5'd0;
        enq_pc = pc; enq_target = tgt; enq_pred_taken = pred; enq_rob_id = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; res_ready = 1'b0; cdb_valid = 1'b0;
        cdb_tag = 5'd0; cdb_data = 32'h0;
        enq_drive(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        enq_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (res_vec !== 40'h0) begin n_err++; $display("FAIL reset_res got %h exp %h", res_vec, 40'h0); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready); end
        n_cmp++; if ({cmp_a, cmp_op} !== 35'h0) begin n_err++; $display("FAIL reset_cmp got %h exp 0", {cmp_a, cmp_op}); end
    endtask

    task automatic test_basic_beq();
        enq_drive(3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 5'd0, 32'h100, 32'h200, 1'b0, 5'd1);
        tick();
        enq_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL beq_latency got %b exp 0", res_valid); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b1, 32'h200, 5'd1}) begin n_err++; $display("FAIL beq_result got %h exp %h", res_vec, {1'b1, 1'b1, 1'b1, 32'h200, 5'd1}); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b1, 32'h200, 5'd1}) begin n_err++; $display("FAIL beq_hold got %h exp %h", res_vec, {1'b1, 1'b1, 1'b1, 32'h200, 5'd1}); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL beq_drain got %b exp 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        enq_drive(3'b100, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 5'd0, 32'h300, 32'h400, 1'b0, 5'd2);
        tick();
        enq_drive(3'b110, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 5'd0, 32'h304, 32'h500, 1'b1, 5'd3);
        tick();
        enq_valid = 1'b0;
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b1, 32'h400, 5'd2}) begin n_err++; $display("FAIL b2b_blt got %h exp %h", res_vec, {1'b1, 1'b1, 1'b1, 32'h400, 5'd2}); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b1, 32'h308, 5'd3}) begin n_err++; $display("FAIL b2b_bltu got %h exp %h", res_vec, {1'b1, 1'b0, 1'b1, 32'h308, 5'd3}); end
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b exp 0", res_valid); end
    endtask

    task automatic test_wakeup();
        res_ready = 1'b1;
        enq_drive(3'b001, 32'h0, 32'd3, 1'b0, 1'b1, 5'd7, 32'h600, 32'h700, 1'b1, 5'd4);
        tick();
        enq_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'd9;
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL wake_early got %b exp 0", res_valid); end
        cdb_tag = 5'd7; cdb_data = 32'd3;
        tick();
        cdb_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL wake_capture_cycle got %b exp 0", res_valid); end
        n_cmp++; if (cmp_a !== 32'd3) begin n_err++; $display("FAIL wake_operand got %h exp %h", cmp_a, 32'd3); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b1, 32'h604, 5'd4}) begin n_err++; $display("FAIL wake_result got %h exp %h", res_vec, {1'b1, 1'b0, 1'b1, 32'h604, 5'd4}); end
        tick();
    endtask

    task automatic test_full();
        res_ready = 1'b0;
        enq_drive(3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 5'd0, 32'h1000, 32'h2000, 1'b1, 5'd8);
        tick();
        enq_drive(3'b001, 32'd1, 32'd1, 1'b1, 1'b1, 5'd0, 32'h1004, 32'h3000, 1'b0, 5'd9);
        tick();
        enq_drive(3'b101, 32'h80000000, 32'd1, 1'b1, 1'b1, 5'd0, 32'h1008, 32'h5000, 1'b1, 5'd10);
        tick();
        enq_drive(3'b111, 32'h80000000, 32'd1, 1'b1, 1'b1, 5'd0, 32'h100C, 32'h4000, 1'b0, 5'd11);
        tick();
        enq_drive(3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0, 32'h1010, 32'h6000, 1'b1, 5'd12);
        tick();
        n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_enq_ready got %b exp 0", enq_ready); end
        enq_drive(3'b001, 32'd4, 32'd5, 1'b1, 1'b1, 5'd0, 32'h1014, 32'h7000, 1'b0, 5'd13);
        tick();
        n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_stall got %b exp 0", enq_ready); end
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b0, 32'h2000, 5'd8}) begin n_err++; $display("FAIL full_hold got %h exp %h", res_vec, {1'b1, 1'b1, 1'b0, 32'h2000, 5'd8}); end
        enq_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b0, 32'h1008, 5'd9}) begin n_err++; $display("FAIL full_r9 got %h exp %h", res_vec, {1'b1, 1'b0, 1'b0, 32'h1008, 5'd9}); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b1, 32'h100C, 5'd10}) begin n_err++; $display("FAIL full_r10 got %h exp %h", res_vec, {1'b1, 1'b0, 1'b1, 32'h100C, 5'd10}); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b1, 32'h4000, 5'd11}) begin n_err++; $display("FAIL full_r11 got %h exp %h", res_vec, {1'b1, 1'b1, 1'b1, 32'h4000, 5'd11}); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b1, 32'h1014, 5'd12}) begin n_err++; $display("FAIL full_r12 got %h exp %h", res_vec, {1'b1, 1'b0, 1'b1, 32'h1014, 5'd12}); end
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b exp 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_flush();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_drive(3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 5'd0, 32'h2000 + 32'(4 * i), 32'h9000, 1'b0, 5'(16 + i));
            tick();
        end
        n_cmp++; if ({res_valid, res_rob_id, enq_ready} !== {1'b1, 5'd16, 1'b1}) begin n_err++; $display("FAIL flush_pre got %h exp %h", {res_valid, res_rob_id, enq_ready}, {1'b1, 5'd16, 1'b1}); end
        flush = 1'b1;
        enq_drive(3'b000, 32'h77, 32'h77, 1'b1, 1'b1, 5'd0, 32'h40, 32'h44, 1'b0, 5'd21);
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        n_cmp++; if ({res_valid, enq_ready} !== 2'b01) begin n_err++; $display("FAIL flush_state got %b exp 01", {res_valid, enq_ready}); end
        n_cmp++; if (cmp_a !== 32'h0) begin n_err++; $display("FAIL flush_discard_enq got %h exp 0", cmp_a); end
        res_ready = 1'b1;
        enq_drive(3'b000, 32'd2, 32'd2, 1'b1, 1'b1, 5'd0, 32'h50, 32'h60, 1'b1, 5'd20);
        tick();
        enq_valid = 1'b0;
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b1, 1'b0, 32'h60, 5'd20}) begin n_err++; $display("FAIL flush_after got %h exp %h", res_vec, {1'b1, 1'b1, 1'b0, 32'h60, 5'd20}); end
        tick();
    endtask

    task automatic test_bypass_wrap();
        res_ready = 1'b1;
        enq_drive(3'b000, 32'h0, 32'h55, 1'b0, 1'b1, 5'd9, 32'hFFFFFFFC, 32'h10, 1'b0, 5'd22);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h54;
        tick();
        enq_valid = 1'b0;
        cdb_valid = 1'b0;
        n_cmp++; if (cmp_a !== 32'h54) begin n_err++; $display("FAIL bypass_operand got %h exp %h", cmp_a, 32'h54); end
        tick();
        n_cmp++; if (res_vec !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd22}) begin n_err++; $display("FAIL bypass_wrap got %h exp %h", res_vec, {1'b1, 1'b0, 1'b0, 32'h0, 5'd22}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_beq();
        test_back_to_back();
        test_wakeup();
        test_full();
        test_flush();
        test_bypass_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/br_sched.md
Name: br_sched

Overview:
- In-order branch scheduling queue for the RV32I branch comparator.
- Buffers decoded branches, captures late operands from the common data bus (CDB), and issues the oldest ready branch to the single external comparator.
- Registers the comparison result and produces a resolution record (taken, mispredict, redirect PC, ROB id) for the ROB and fetch.
- Sits between dispatch and ROB/fetch redirect; owns sequencing of the shared comparator.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
TAG_W, 5, physical/ROB tag width for operand wakeup
ROB_W, 5, ROB id width carried to resolution

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  clear all queued and in-flight branches
enq_valid  in  1  dispatch presents a branch
enq_ready  out  1  queue can accept (count < DEPTH)
enq_cmp_op  in  3  funct3: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111
enq_a / enq_b  in  32 each  operand values (meaningful when rdy=1)
enq_a_rdy / enq_b_rdy  in  1 each  operand already available
enq_a_tag / enq_b_tag  in  TAG_W each  producer tag when not ready
enq_pc  in  32  branch PC
enq_target  in  32  taken target
enq_pred_taken  in  1  front-end prediction
enq_rob_id  in  ROB_W  ROB id
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  32  broadcast value
cmp_a / cmp_b  out  32 each  comparator operands
cmp_op  out  3  comparator op
cmp_br_en  in  1  comparator result (combinational from cmp_a/b/op)
res_valid  out  1  resolution record valid
res_ready  in  1  consumer accepts
res_taken  out  1  actual outcome
res_mispredict  out  1  res_taken != pred_taken
res_redirect_pc  out  32  taken ? target : pc+4
res_rob_id  out  ROB_W  ROB id

Behaviour:
- Reset (rst=1 at clk edge): head=tail=count=0; all entries invalid; res_valid=0; res_taken/res_mispredict/res_redirect_pc/res_rob_id=0; enq_ready=1 in the cycle after reset.
- Circular FIFO: head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- enq_ready = (count != DEPTH). It does not depend on a same-cycle issue.
- Enqueue occurs on enq_valid & enq_ready & !flush. The entry is written at tail.
- Wakeup: every valid entry with a not-ready operand whose tag == cdb_tag while cdb_valid=1 captures cdb_data and sets rdy. Both operands may wake in the same cycle.
- Enqueue bypass: an operand arriving with rdy=0 and a tag matching the same-cycle CDB broadcast is stored ready with cdb_data.
- Issue: only the head entry may issue.
- Issue condition: count>0, head a_rdy and b_rdy, (res_valid==0 or res_ready==1), and !flush.
- On issue: head advances, count decrements, and cmp_a/cmp_b/cmp_op are driven from the head entry in the same cycle.
- When not issuing, cmp_a/cmp_b/cmp_op hold the head entry values (or 0 when empty). Consumers ignore cmp_br_en.
- Result register is loaded at the issue edge:
  - res_taken = cmp_br_en, forced 0 for funct3 010/011.
  - res_mispredict = res_taken ^ pred_taken.
  - res_redirect_pc = taken ? target : pc+4, 32-bit wrap.
- Latency: enqueue at edge N with both operands ready → issue in cycle N+1 → res_valid=1 in cycle N+2.
- Output handshake: transfer occurs when res_valid & res_ready. While res_valid=1 and res_ready=0, all res_* outputs hold stable and no issue occurs.
- Simultaneous transfer and issue (res_ready=1 with res_valid=1) gives back-to-back results, 1 per cycle.
- Simultaneous enqueue and issue: count unchanged.
- Flush at edge: count=0, head=tail=0, res_valid=0. An enqueue, issue or wakeup in the same cycle is discarded. flush has priority over everything except rst.
- Full: enq_valid with count=DEPTH is stalled, not dropped; dispatch holds its inputs.
- Empty: no issue; res_valid falls after the final transfer.

Test Plan:
- Reset, then enqueue beq a=5 b=5 pc=0x100 target=0x200 pred=0, both ready → res_valid 2 cycles later; taken=1, mispredict=1, redirect=0x200.
- Enqueue blt a=0xFFFFFFFF b=1 and bltu with the same operands, back to back with res_ready=1 → taken=1 then taken=0 on consecutive cycles, redirect of the second = pc+4.
- Enqueue bne with a not ready (tag 7); CDB tag 7 data 3 two cycles later; b=3 → no issue before wakeup; then taken=0, mispredict=pred.
- Fill all DEPTH=4 entries with res_ready=0 → enq_ready=0, res_* outputs stable; raise res_ready → four results in order of ROB id, one per cycle.
- Assert flush with 3 queued entries and res_valid=1 → next cycle res_valid=0, enq_ready=1, and the next enqueue resolves normally.
- Enqueue with a_tag matching a same-cycle CDB broadcast, pc=0xFFFFFFFC, not taken → operand captured and redirect_pc=0x00000000 (wrap).
